// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared cpu definitions: next-PC source encoding and default vectors
package cpu_pkg;

  typedef enum logic [2:0] {
    SRC_EXC,
    SRC_REDIR,
    SRC_RET,
    SRC_HOLD,
    SRC_SEQ
  } next_src_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0080;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack; a push on a full stack overwrites the oldest entry
module pc_ras #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [PW-1:0] LAST_IDX   = PW'(RAS_DEPTH - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_inc;
  logic [PW-1:0]    ptr_dec;
  logic [CW-1:0]    count;
  logic             do_replace;
  logic             do_push;
  logic             do_pop;

  // ptr always indexes the current top entry; count saturates at RAS_DEPTH
  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign top     = mem[ptr];
  assign ptr_inc = (ptr == LAST_IDX) ? '0 : ptr + 1'b1;
  assign ptr_dec = (ptr == '0) ? LAST_IDX : ptr - 1'b1;

  // simultaneous push and pop on a non-empty stack swaps the top in place
  assign do_replace = push && pop && !empty;
  assign do_push    = push && !do_replace;
  assign do_pop     = pop && !push && !empty;

  // pointer and occupancy; these are the only reset state of the stack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (clear) begin
      ptr   <= '0;
      count <= '0;
    end else if (do_push) begin
      ptr   <= ptr_inc;
      count <= full ? count : count + 1'b1;
    end else if (do_pop) begin
      ptr   <= ptr_dec;
      count <= count - 1'b1;
    end
  end

  // entry storage, written on push (next slot) or replace (current top)
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (do_push) begin
        mem[ptr_inc] <= push_data;
      end else if (do_replace) begin
        mem[ptr] <= push_data;
      end
    end
  end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with exception/redirect/return selection and a return-address stack
module pc_unit import cpu_pkg::*; #(
  parameter int             WIDTH        = 32,
  parameter int             STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEFAULT_EXC_VECTOR),
  parameter int             RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             exc_valid,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc_out,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             misalign
);

  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

  next_src_t        src;
  logic [WIDTH-1:0] pc_seq;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] ras_top;
  logic             ras_active;
  logic             target_misaligned;

  assign pc_seq            = pc_out + STEP_W;
  assign target_misaligned = |(redirect_target & ALIGN_MASK);
  // call/ret only touch the stack when nothing higher-priority owns the cycle
  assign ras_active        = !exc_valid && !redirect_valid && !stall;

  // pick the next-PC source by priority and form the next PC
  always_comb begin
    src     = SRC_SEQ;
    pc_next = pc_seq;
    if (exc_valid) begin
      src = SRC_EXC;
    end else if (redirect_valid) begin
      src = SRC_REDIR;
    end else if (stall) begin
      src = SRC_HOLD;
    end else if (ret && !ras_empty) begin
      src = SRC_RET;
    end
    case (src)
      SRC_EXC:   pc_next = EXC_VECTOR;
      SRC_REDIR: pc_next = redirect_target & ~ALIGN_MASK;
      SRC_RET:   pc_next = ras_top;
      SRC_HOLD:  pc_next = pc_out;
      default:   pc_next = pc_seq;
    endcase
  end

  // PC and misalign flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_out   <= RESET_VECTOR;
      misalign <= 1'b0;
    end else begin
      pc_out   <= pc_next;
      misalign <= (src == SRC_REDIR) && target_misaligned;
    end
  end

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .clear     (exc_valid),
    .push      (ras_active && call),
    .pop       (ras_active && ret),
    .push_data (pc_seq),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking bench for pc_unit against a queue-based reference model
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        exc_valid = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [31:0] pc_out;
  logic        ras_empty;
  logic        ras_full;
  logic        misalign;

  logic        reset8 = 1'b1;
  logic        redirect_valid8 = 1'b0;
  logic [7:0]  redirect_target8 = '0;
  logic [7:0]  pc_out8;
  logic        ras_empty8;
  logic        ras_full8;
  logic        misalign8;

  int total = 0;
  int bad = 0;

  logic [31:0] m_pc;
  logic        m_mis;
  logic [31:0] m_ras[$];

  always #5 clk = ~clk;

  pc_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .exc_valid       (exc_valid),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .call            (call),
    .ret             (ret),
    .pc_out          (pc_out),
    .ras_empty       (ras_empty),
    .ras_full        (ras_full),
    .misalign        (misalign)
  );

  pc_unit #(.WIDTH(8)) dut8 (
    .clk             (clk),
    .reset           (reset8),
    .stall           (1'b0),
    .exc_valid       (1'b0),
    .redirect_valid  (redirect_valid8),
    .redirect_target (redirect_target8),
    .call            (1'b0),
    .ret             (1'b0),
    .pc_out          (pc_out8),
    .ras_empty       (ras_empty8),
    .ras_full        (ras_full8),
    .misalign        (misalign8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc  = 32'h0;
    m_mis = 1'b0;
    m_ras.delete();
  endtask

  // one clock of architectural behaviour: priority exc > redirect > stall > call/ret > sequential
  task automatic model_step(input bit e, input bit r, input logic [31:0] t,
                            input bit s, input bit c, input bit rt);
    logic [31:0] ra;
    m_mis = 1'b0;
    if (e) begin
      m_pc = 32'h80;
      m_ras.delete();
    end else if (r) begin
      m_mis = (t % 4) != 0;
      m_pc  = t - (t % 4);
    end else if (!s) begin
      ra = m_pc + 32'd4;
      if (rt && m_ras.size() > 0) begin
        m_pc = m_ras.pop_back();
        if (c) m_ras.push_back(ra);
      end else begin
        if (c) begin
          m_ras.push_back(ra);
          if (m_ras.size() > 4) void'(m_ras.pop_front());
        end
        m_pc = ra;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"}, pc_out, m_pc);
    check({tag, ".empty"}, {31'b0, ras_empty}, {31'b0, m_ras.size() == 0});
    check({tag, ".full"}, {31'b0, ras_full}, {31'b0, m_ras.size() == 4});
    check({tag, ".mis"}, {31'b0, misalign}, {31'b0, m_mis});
  endtask

  // drive one cycle of inputs, advance the model at the edge, compare at the falling edge
  task automatic cycle(input string tag, input bit e, input bit r, input logic [31:0] t,
                       input bit s, input bit c, input bit rt);
    exc_valid       = e;
    redirect_valid  = r;
    redirect_target = t;
    stall           = s;
    call            = c;
    ret             = rt;
    @(posedge clk);
    model_step(e, r, t, s, c, rt);
    @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    logic [31:0] base;
    bit e, r, s, c, rt;
    logic [31:0] t;

    model_reset();
    @(negedge clk);
    check("rst.pc", pc_out, 32'h0);
    check("rst.empty", {31'b0, ras_empty}, 32'd1);
    check("rst.full", {31'b0, ras_full}, 32'd0);
    check("rst.mis", {31'b0, misalign}, 32'd0);
    reset = 1'b0;

    cycle("free1", 0, 0, 0, 0, 0, 0);
    check("free1.c", pc_out, 32'h4);
    cycle("free2", 0, 0, 0, 0, 0, 0);
    check("free2.c", pc_out, 32'h8);
    cycle("free3", 0, 0, 0, 0, 0, 0);
    check("free3.c", pc_out, 32'hC);

    cycle("call_c", 0, 0, 0, 0, 1, 0);
    check("call_c.c", pc_out, 32'h10);
    check("call_c.ne", {31'b0, ras_empty}, 32'd0);
    cycle("exc", 1, 1, 32'h40, 1, 0, 0);
    check("exc.c", pc_out, 32'h80);
    check("exc.empty", {31'b0, ras_empty}, 32'd1);

    cycle("mis", 0, 1, 32'h42, 0, 0, 0);
    check("mis.pc", pc_out, 32'h40);
    check("mis.hi", {31'b0, misalign}, 32'd1);
    cycle("mis2", 0, 0, 0, 0, 0, 0);
    check("mis2.lo", {31'b0, misalign}, 32'd0);

    for (int i = 1; i <= 5; i++) begin
      base = 32'(i) << 8;
      cycle("ras_redir", 0, 1, base, 0, 0, 0);
      cycle("ras_call", 0, 0, 0, 0, 1, 0);
    end
    check("ras.full", {31'b0, ras_full}, 32'd1);
    cycle("ret1", 0, 0, 0, 0, 0, 1);
    check("ret1.c", pc_out, 32'h504);
    cycle("ret2", 0, 0, 0, 0, 0, 1);
    check("ret2.c", pc_out, 32'h404);
    cycle("ret3", 0, 0, 0, 0, 0, 1);
    check("ret3.c", pc_out, 32'h304);
    cycle("ret4", 0, 0, 0, 0, 0, 1);
    check("ret4.c", pc_out, 32'h204);
    check("ret4.empty", {31'b0, ras_empty}, 32'd1);
    cycle("ret5", 0, 0, 0, 0, 0, 1);
    check("ret5.c", pc_out, 32'h208);

    cycle("cr_redir", 0, 1, 32'h80, 0, 0, 0);
    cycle("cr_call", 0, 0, 0, 0, 1, 0);
    cycle("cr_redir2", 0, 1, 32'h20, 0, 0, 0);
    cycle("cr_both", 0, 0, 0, 0, 1, 1);
    check("cr_both.c", pc_out, 32'h84);
    check("cr_both.ne", {31'b0, ras_empty}, 32'd0);
    cycle("cr_ret", 0, 0, 0, 0, 0, 1);
    check("cr_ret.c", pc_out, 32'h24);
    check("cr_ret.empty", {31'b0, ras_empty}, 32'd1);

    cycle("stall_call", 0, 0, 0, 1, 1, 0);
    check("stall_call.c", pc_out, 32'h24);
    check("stall_call.e", {31'b0, ras_empty}, 32'd1);

    cycle("mid_call", 0, 0, 0, 0, 1, 0);
    exc_valid = 0; stall = 0; ret = 0;
    redirect_valid = 1; redirect_target = 32'h302; call = 1;
    #2 reset = 1'b1;
    #1;
    check("mid.pc", pc_out, 32'h0);
    check("mid.empty", {31'b0, ras_empty}, 32'd1);
    check("mid.mis", {31'b0, misalign}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_model("mid_after");

    for (int i = 0; i < 400; i++) begin
      e  = ($urandom_range(0, 31) == 0);
      r  = ($urandom_range(0, 7) == 0);
      t  = 32'($urandom_range(0, 'h3ff));
      s  = ($urandom_range(0, 5) == 0);
      c  = ($urandom_range(0, 2) == 0);
      rt = !s && ($urandom_range(0, 2) == 0);
      cycle("rand", e, r, t, s, c, rt);
    end
    cycle("idle", 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    reset8 = 1'b0;
    redirect_valid8 = 1'b1;
    redirect_target8 = 8'hFC;
    @(negedge clk);
    redirect_valid8 = 1'b0;
    check("w8.fc", {24'b0, pc_out8}, 32'hFC);
    @(negedge clk);
    check("w8.wrap", {24'b0, pc_out8}, 32'h00);
    check("w8.empty", {31'b0, ras_empty8}, 32'd1);
    check("w8.full", {31'b0, ras_full8}, 32'd0);
    check("w8.mis", {31'b0, misalign8}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
